time_display_scan: RTL
======================

# time_display_scan

Multiplexed six-digit seven-segment driver for the time-of-day, alarm and stopwatch block. It sits directly downstream of that block and consumes its binary `hours`/`mins`/`secs` and `buzzer` outputs. It converts each field to two BCD digits and scans the digits onto a common-anode display. Inputs are snapshotted once per scan frame, so a displayed frame never mixes old and new time.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency.
- `SCAN_HZ`, default 1000: digit refresh rate. `DIV = CLK_HZ/SCAN_HZ` must be ≥ 3, enforced by an elaboration check.
- `BLINK_FRAMES`, default 128: frames per blink half-period; used only with `DISPLAY_BLINK_EN`.
- Reset and clock are fixed: reset `reset`, asynchronous, active-high; clock `clk`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `hours` in 5: binary 0..23.
- `mins` in 6: binary 0..59.
- `secs` in 6: binary 0..59.
- `alarm` in 1: buzzer level from the time block.
- `an` out 6: digit anodes, active-low; `an[0]` is the rightmost digit.
- `seg` out 7: segments, active-low, bit order {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point, active-low.
- `frame_start` out 1: one-cycle pulse on the edge the snapshot is taken.

## Operation
- Prescaler `cnt` counts 0..DIV-1. `tick` is asserted when `cnt == DIV-1`. On the tick edge, `cnt` returns to 0.
- Digit index `idx` (0..5) increments on each tick edge and wraps 5→0.
- Digit map:
  - idx0: secs ones
  - idx1: secs tens
  - idx2: mins ones
  - idx3: mins tens
  - idx4: hours ones
  - idx5: hours tens
- Snapshot registers capture `hours`, `mins`, `secs` and `alarm` on the tick edge where `idx` wraps 5→0. `frame_start` pulses high for that one cycle.
- Changes to the inputs mid-frame are not displayed until the next frame.
- BCD split per field: tens = v/10, ones = v%10. Leading zeros are displayed.
- Out-of-range fields (hours > 23, mins > 59, secs > 59) display as two dashes (segment g only, `seg = 7'h3F`) on both digits of that field. Other fields are unaffected.
- Segment codes (active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - dash=3F, blank=7F
- `dp` is driven low on idx2 and idx4 as field separators, and high elsewhere.
- Anti-ghosting: a `blank` flag is set on every tick edge and cleared on the next edge. While the outputs are blanked, `an = 6'b111111`.
- Outputs `an`, `seg` and `dp` are registered from the state `idx`, snapshot and `blank`.

## Timing
- Reset, applied asynchronously at any time including mid-frame, sets:
  - `an = 6'b111111`, `seg = 7'h7F`, `dp = 1`, `frame_start = 0`
  - `cnt = 0`, `idx = 0`, snapshot = 0, `blank = 0`
- After reset release, the display shows 00:00:00, starting with digit 0, until the first frame wrap.
- For a tick sampled at edge T:
  - T: `idx` updates and `blank` is set.
  - T+1: outputs are blank.
  - T+2 onward: the new digit is shown until the next tick's T+1.
- Each digit is lit for DIV-1 cycles. One frame is 6·DIV cycles.
- A frame-wrap tick and an input change in the same cycle: the value present at that edge is captured.
- The first frame after reset is a full frame.

## Configuration
- `DISPLAY_BLINK_EN` defined:
  - While the snapshotted `alarm` is 1, a blink frame counter toggles phase every `BLINK_FRAMES` frames.
  - During the off phase, `an = 6'b111111` for whole frames.
  - When the snapshotted `alarm` is 0, the counter and phase reset to the on phase.
- `DISPLAY_BLINK_EN` undefined: the `alarm` port is present but ignored, and there is no blink logic.

## Structure
- Package `display_pkg` holds:
  - `NUM_DIGITS = 6`
  - the digit-index typedef (3 bits)
  - segment code constants for 0–9, dash and blank
  - the BCD split function
- Sub-module `seg7_decode` is combinational. It maps a 4-bit code plus a dash flag to `seg[6:0]`, and is instantiated once after the digit mux.

## Test plan
Benches use `DIV = 4` and `BLINK_FRAMES = 2`.
- Reset mid-scan, with reset asserted between clock edges → `an = 111111`, `seg = 7F`, `dp = 1` immediately. After release, idx0 shows `seg = 40`.
- Input 12:34:56, wait for `frame_start` → idx0 shows `an = 111110`, `seg = 02`; idx5 shows `an = 011111`, `seg = 79`; idx2 shows `dp = 0`. A one-cycle `an = 111111` gap precedes each digit.
- Change the input to 23:59:59 during idx3 → the current frame still shows 12:34:56. The next frame shows `seg = 10` on idx0 and `seg = 24` on idx5.
- Input hours = 24, secs = 63, mins = 7 → idx0, idx1, idx4 and idx5 show `seg = 3F`; idx2 shows `seg = 78`; idx3 shows `seg = 40`.
- `frame_start` period is exactly 24 cycles, and each digit is lit for exactly 3 cycles.
- With `DISPLAY_BLINK_EN` and `alarm = 1`: 2 frames lit, then 2 frames with `an = 111111`, repeating. Dropping `alarm` → the display is lit from the next frame on.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, digit index type and BCD helper for the time display scanner
// Contents: NUM_DIGITS, digit_idx_t, active-low segment codes {g,f,e,d,c,b,a}, bcd_split().
package display_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [2:0] digit_idx_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Returns {tens, ones}; only meaningful for v <= 99, callers flag larger values.
    function automatic logic [7:0] bcd_split(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD/dash to active-low seven-segment decoder
// Ports: code (4-bit BCD digit), dash (force dash), seg (active-low {g,f,e,d,c,b,a}).
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else begin
            case (code)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/time_display_scan.sv
// rtl/time_display_scan.sv - six-digit multiplexed seven-segment scanner for hh:mm:ss
// Parameters: CLK_HZ, SCAN_HZ (DIV = CLK_HZ/SCAN_HZ >= 3), BLINK_FRAMES (alarm blink half-period in frames).
// Ports: clk, reset (async, active-high), hours/mins/secs (binary), alarm (buzzer level),
//        an (active-low anodes, an[0] rightmost), seg (active-low {g,f,e,d,c,b,a}), dp (active-low),
//        frame_start (one-cycle pulse when the inputs are snapshotted).
// Option: define DISPLAY_BLINK_EN to blink the whole display while the snapshotted alarm is high.
module time_display_scan
    import display_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] hours,
    input  logic [5:0] mins,
    input  logic [5:0] secs,
    input  logic       alarm,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

    if (DIV < 3) begin : g_bad_div
        $error("time_display_scan: CLK_HZ/SCAN_HZ must be at least 3");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("time_display_scan: BLINK_FRAMES must be at least 1");
    end

    logic [CW-1:0] cnt;
    digit_idx_t    idx;
    logic          blank;
    logic [4:0]    snap_hours;
    logic [5:0]    snap_mins;
    logic [5:0]    snap_secs;

    logic tick;
    logic wrap;
    logic dark;

    assign tick = (cnt == CW'(DIV - 1));
    assign wrap = tick && (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            blank       <= 1'b0;
            snap_hours  <= '0;
            snap_mins   <= '0;
            snap_secs   <= '0;
            frame_start <= 1'b0;
        end else begin
            // Blank for one cycle after every digit change so the old segments never
            // appear on the new anode.
            blank       <= tick;
            frame_start <= wrap;
            if (tick) begin
                cnt <= '0;
                idx <= (idx == LAST_IDX) ? '0 : idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (wrap) begin
                snap_hours <= hours;
                snap_mins  <= mins;
                snap_secs  <= secs;
            end
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic          snap_alarm;
    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    // Blink state advances once per frame using the alarm level of the frame just
    // ending, so the first alarmed frame is always lit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_alarm <= 1'b0;
            blink_cnt  <= '0;
            blink_off  <= 1'b0;
        end else if (wrap) begin
            snap_alarm <= alarm;
            if (!snap_alarm) begin
                blink_cnt <= '0;
                blink_off <= 1'b0;
            end else if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Masking with the snapshot lights the display on the first frame after alarm drops.
    assign dark = blink_off & snap_alarm;
`else
    logic alarm_unused;
    assign alarm_unused = alarm;
    assign dark         = 1'b0;
`endif

    logic [5:0] field;
    logic       over;
    logic [7:0] bcd;
    logic [3:0] code;
    logic [6:0] seg_next;
    logic [5:0] an_next;
    logic       dp_next;

    // Digit pairs: idx 0/1 secs, 2/3 mins, 4/5 hours; odd index is the tens digit.
    always_comb begin
        field = snap_secs;
        over  = (snap_secs > 6'd59);
        case (idx)
            3'd2, 3'd3: begin
                field = snap_mins;
                over  = (snap_mins > 6'd59);
            end
            3'd4, 3'd5: begin
                field = {1'b0, snap_hours};
                over  = (snap_hours > 5'd23);
            end
            default: ;
        endcase
        bcd     = bcd_split(field);
        code    = idx[0] ? bcd[7:4] : bcd[3:0];
        an_next = (blank || dark) ? 6'h3F : ~(6'd1 << idx);
        dp_next = blank ? 1'b1 : !((idx == 3'd2) || (idx == 3'd4));
    end

    seg7_decode u_decode (
        .code (code),
        .dash (over),
        .seg  (seg_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 6'h3F;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule
